detect_event_counter: RTL and testbench
=======================================

Name: detect_event_counter

Overview:
- Downstream stage of the 4-equal-bit sequence detector; consumes its detector output z.
- Counts detection events, where an event is a rising edge of z. A run of z held high counts once.
- Keeps the count as a multi-digit BCD value and drives active-low 7-segment patterns for board display.
- Provides a one-cycle event strobe and a sticky overflow flag.

Parameters:
- DIGITS, 2, number of BCD digits in the counter (1..4).
- SEG_ACTIVE_LOW, 1, 1 = segment outputs active-low (DE-board style); 0 = active-high.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- aclr  input  1  asynchronous, active-high reset.
- z  input  1  detector output, synchronous to clk.
- clr_cnt  input  1  synchronous counter clear.
- event_p  output  1  one-cycle strobe, registered, marks a counted event.
- count  output  4*DIGITS  BCD count; digit 0 is in bits [3:0].
- ovf  output  1  sticky wrap flag.
- hex  output  7*DIGITS  segment patterns, digit i in bits [7i+6:7i], segment order g..a (MSB..LSB).

Behaviour:
- Reset (aclr=1, asynchronous) sets:
  - FSM to S_LOW
  - event_p=0, count=0, ovf=0
  - hex = pattern for "0" on every digit
- FSM is Moore with two states:
  - S_LOW: z=1 -> S_HIGH, event_p=1 next cycle, count increments. z=0 -> stay.
  - S_HIGH: z=0 -> S_LOW. z=1 -> stay, no event.
- Latency: z first sampled 1 at edge k -> event_p=1 and the incremented count are both visible after edge k. event_p drops after edge k+1.
- z already high on the first edge after reset release counts as an event, because reset state is S_LOW.
- Minimum event spacing is 2 cycles (high, low, high). A z pattern of 1,0,1 on consecutive edges gives two events.
- BCD increment:
  - Digit 0 increments; a digit at 9 rolls to 0 and carries into the next digit.
  - No digit ever holds 10..15.
- Wrap: count at all-9s plus an event -> count=0, ovf=1. ovf stays 1 until clr_cnt or aclr.
- clr_cnt=1 on an edge forces count=0 and ovf=0, and overrides any simultaneous increment. The FSM still advances, and event_p still pulses if an edge of z is detected that cycle.
- hex is combinational from count; no extra latency beyond count.
  - Digits 0..9 use standard patterns.
  - Inversion is applied when SEG_ACTIVE_LOW=1.
- aclr asserted mid-run clears everything immediately, independent of clk.

Optional Feature:
- Macro DETECT_COUNT_SATURATE_EN.
- When defined: count holds at all-9s instead of wrapping. ovf is set on the first event attempted at all-9s. event_p still pulses.
- When undefined: wrap-around behaviour as above.

Decomposition:
- Shared package detect_pkg holds:
  - the state typedef (S_LOW, S_HIGH)
  - the 7-segment pattern constants for 0..9 and blank
  - the BCD digit width constant (4)
- Natural sub-module: bcd_to_seg7, a combinational single-digit decoder instantiated DIGITS times with polarity selected by SEG_ACTIVE_LOW.

Test Plan (DIGITS=2, SEG_ACTIVE_LOW=1):
- aclr=1 pulsed mid-cycle, then released -> count=8'h00, ovf=0, event_p=0, hex=14'b1000000_1000000 with no clock edge needed.
- z=1 held for 5 cycles, then 0 -> exactly one event_p pulse, one cycle after the first high sample; count=8'h01.
- z pattern 1,0,1,0,1 -> three event_p pulses; count=8'h03.
- Drive 9 events from count 8'h00 -> count=8'h09; one more event -> count=8'h10, hex digit0=1000000, digit1=1111001.
- Preload to 8'h99 via 99 events, then one more event -> count=8'h00 and ovf=1. With DETECT_COUNT_SATURATE_EN defined: count=8'h99, ovf=1.
- clr_cnt=1 on the same edge as a rising z with count=8'h42 -> count=8'h00, ovf=0, event_p=1, FSM in S_HIGH (no second event while z stays 1).

Source files
------------

// File: rtl/detect_pkg.sv
// Shared types and constants for the detection event counter: FSM states,
// BCD digit width and active-high 7-segment patterns (segment order g..a).
package detect_pkg;

  typedef enum logic {
    S_LOW  = 1'b0,
    S_HIGH = 1'b1
  } state_t;

  localparam int BCD_W = 4;
  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  // Codes 10..15 never occur in the counter; they decode to blank.
  function automatic logic [SEG_W-1:0] seg7_pattern(input logic [BCD_W-1:0] bcd);
    logic [SEG_W-1:0] pat;
    case (bcd)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Single-digit BCD to 7-segment decoder, segment order g..a.
// ACTIVE_LOW=1 inverts the pattern for common-anode style boards.
module bcd_to_seg7
  import detect_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [BCD_W-1:0] i_bcd,
  output logic [SEG_W-1:0] o_seg
);

  logic [SEG_W-1:0] w_seg_hi;

  always_comb begin
    w_seg_hi = seg7_pattern(i_bcd);
    o_seg    = ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;
  end

endmodule

// File: rtl/detect_event_counter.sv
// Counts rising edges of detector output z into a BCD counter with 7-seg display.
// Define DETECT_COUNT_SATURATE_EN to hold at all-9s instead of wrapping.
//
// state  | meaning
// S_LOW  | z last sampled low; next high sample is a new event
// S_HIGH | z last sampled high; held-high z is not counted again
module detect_event_counter
  import detect_pkg::*;
#(
  parameter int DIGITS         = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  z,
  input  logic                  clr_cnt,
  output logic                  event_p,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                  ovf,
  output logic [SEG_W*DIGITS-1:0] hex
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_event_nxt;
  logic   r_event_p;

  logic [BCD_W*DIGITS-1:0] r_count;
  logic [BCD_W*DIGITS-1:0] w_count_inc;
  logic                    w_carry;
  logic                    w_all9;
  logic                    r_ovf;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_state   <= S_LOW;
      r_event_p <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_event_p <= w_event_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_event_nxt = 1'b0;
    case (r_state)
      S_LOW: begin
        if (z) begin
          w_state_nxt = S_HIGH;
          w_event_nxt = 1'b1;
        end
      end
      S_HIGH: begin
        if (!z) w_state_nxt = S_LOW;
      end
      default: w_state_nxt = S_LOW;
    endcase
  end

  // Ripple BCD increment; a carry out of the top digit means the count was all-9s.
  always_comb begin
    w_carry     = 1'b1;
    w_count_inc = r_count;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_carry) begin
        if (r_count[i*BCD_W +: BCD_W] >= 4'd9) begin
          w_count_inc[i*BCD_W +: BCD_W] = '0;
        end else begin
          w_count_inc[i*BCD_W +: BCD_W] = r_count[i*BCD_W +: BCD_W] + 4'd1;
          w_carry                       = 1'b0;
        end
      end
    end
    w_all9 = w_carry;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (clr_cnt) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_event_nxt) begin
`ifdef DETECT_COUNT_SATURATE_EN
      if (w_all9) r_ovf <= 1'b1;
      else        r_count <= w_count_inc;
`else
      r_count <= w_count_inc;
      if (w_all9) r_ovf <= 1'b1;
`endif
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
    bcd_to_seg7 #(
      .ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_seg (
      .i_bcd(r_count[gi*BCD_W +: BCD_W]),
      .o_seg(hex[gi*SEG_W +: SEG_W])
    );
  end

  assign event_p = r_event_p;
  assign count   = r_count;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_detect_event_counter.sv
// Bench for detect_event_counter (DIGITS=2, active-low segments): integer
// reference model checked every cycle plus directed literal expectations.
module tb_detect_event_counter;

  logic        clk;
  logic        aclr;
  logic        z;
  logic        clr_cnt;
  logic        event_p;
  logic [7:0]  count;
  logic        ovf;
  logic [13:0] hex;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  bit chk_en = 0;

  int m_cnt;
  bit m_ovf;
  bit m_ev;
  bit m_prev_z;

  detect_event_counter #(.DIGITS(2), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .aclr(aclr), .z(z), .clr_cnt(clr_cnt),
    .event_p(event_p), .count(count), .ovf(ovf), .hex(hex)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_lo(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Event = z high now but low on the previous edge (low after reset).
  always @(posedge clk or posedge aclr) begin
    if (aclr) begin
      m_cnt = 0; m_ovf = 0; m_ev = 0; m_prev_z = 0;
    end else begin
      m_ev     = z && !m_prev_z;
      m_prev_z = z;
      if (clr_cnt) begin
        m_cnt = 0; m_ovf = 0;
      end else if (m_ev) begin
        if (m_cnt == 99) begin
          m_ovf = 1;
`ifndef DETECT_COUNT_SATURATE_EN
          m_cnt = 0;
`endif
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (event_p === 1'b1) pulses++;
    if (chk_en && !aclr) begin
      check("model_event_p", {31'd0, event_p}, {31'd0, m_ev});
      check("model_count", {24'd0, count}, {24'd0, 4'((m_cnt / 10) % 10), 4'(m_cnt % 10)});
      check("model_ovf", {31'd0, ovf}, {31'd0, m_ovf});
      check("model_hex", {18'd0, hex}, {18'd0, seg_lo((m_cnt / 10) % 10), seg_lo(m_cnt % 10)});
    end
  end

  task automatic set_in(input logic zv, input logic cv);
    @(negedge clk);
    #1;
    z = zv;
    clr_cnt = cv;
  endtask

  task automatic do_event();
    set_in(1'b1, 1'b0);
    set_in(1'b0, 1'b0);
    @(posedge clk);
  endtask

  int p0;

  initial begin
    aclr = 1'b1; z = 1'b0; clr_cnt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1 aclr = 1'b0;
    chk_en = 1;

    repeat (3) do_event();
    @(posedge clk); #1;
    check("pre_reset_count", {24'd0, count}, 32'h03);

    // Asynchronous clear mid-cycle, away from any clock edge.
    @(posedge clk); #2 aclr = 1'b1;
    #1;
    check("aclr_count", {24'd0, count}, 32'h00);
    check("aclr_ovf", {31'd0, ovf}, 32'd0);
    check("aclr_event_p", {31'd0, event_p}, 32'd0);
    check("aclr_hex", {18'd0, hex}, {18'd0, 14'b1000000_1000000});
    check("aclr_model_cnt", m_cnt, 0);
    #1 aclr = 1'b0;

    // z held high 5 cycles: one event, one cycle after first high sample.
    p0 = pulses;
    set_in(1'b1, 1'b0);
    @(posedge clk); #1;
    check("hold_first_event_p", {31'd0, event_p}, 32'd1);
    check("hold_first_count", {24'd0, count}, 32'h01);
    @(posedge clk); #1;
    check("hold_second_event_p", {31'd0, event_p}, 32'd0);
    repeat (3) @(posedge clk);
    set_in(1'b0, 1'b0);
    @(posedge clk); @(negedge clk); #1;
    check("hold_pulses", pulses - p0, 1);
    check("hold_count", {24'd0, count}, 32'h01);

    // 1,0,1,0,1 on consecutive edges -> three events.
    p0 = pulses;
    set_in(1'b0, 1'b1);
    set_in(1'b1, 1'b0);
    set_in(1'b0, 1'b0);
    set_in(1'b1, 1'b0);
    set_in(1'b0, 1'b0);
    set_in(1'b1, 1'b0);
    set_in(1'b0, 1'b0);
    @(posedge clk); @(negedge clk); #1;
    check("alt_pulses", pulses - p0, 3);
    check("alt_count", {24'd0, count}, 32'h03);

    // Digit carry 09 -> 10.
    set_in(1'b0, 1'b1);
    set_in(1'b0, 1'b0);
    repeat (9) do_event();
    #1;
    check("nine_count", {24'd0, count}, 32'h09);
    do_event();
    #1;
    check("ten_count", {24'd0, count}, 32'h10);
    check("ten_hex", {18'd0, hex}, {18'd0, 14'b1111001_1000000});
    check("ten_model_cnt", m_cnt, 10);

    // Up to 99, then overflow.
    repeat (89) do_event();
    #1;
    check("n99_count", {24'd0, count}, 32'h99);
    check("n99_hex", {18'd0, hex}, {18'd0, 14'b0010000_0010000});
    check("n99_ovf", {31'd0, ovf}, 32'd0);
    do_event();
    #1;
`ifdef DETECT_COUNT_SATURATE_EN
    check("wrap_count", {24'd0, count}, 32'h99);
`else
    check("wrap_count", {24'd0, count}, 32'h00);
`endif
    check("wrap_ovf", {31'd0, ovf}, 32'd1);
    do_event();
    #1;
`ifdef DETECT_COUNT_SATURATE_EN
    check("post_wrap_count", {24'd0, count}, 32'h99);
`else
    check("post_wrap_count", {24'd0, count}, 32'h01);
`endif
    check("ovf_sticky", {31'd0, ovf}, 32'd1);

    // clr_cnt clears ovf, then overrides a coincident increment.
    set_in(1'b0, 1'b1);
    set_in(1'b0, 1'b0);
    @(posedge clk); #1;
    check("clr_count", {24'd0, count}, 32'h00);
    check("clr_ovf", {31'd0, ovf}, 32'd0);
    repeat (42) do_event();
    #1;
    check("n42_count", {24'd0, count}, 32'h42);
    set_in(1'b1, 1'b1);
    @(posedge clk); #1;
    check("clr_rise_count", {24'd0, count}, 32'h00);
    check("clr_rise_ovf", {31'd0, ovf}, 32'd0);
    check("clr_rise_event_p", {31'd0, event_p}, 32'd1);
    set_in(1'b1, 1'b0);
    @(posedge clk); #1;
    check("clr_hold_event_p", {31'd0, event_p}, 32'd0);
    check("clr_hold_count", {24'd0, count}, 32'h00);
    set_in(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
